pipe_spawner: RTL and testbench

Source end of the pipe-column shift chain in the 8x8 Flappy Bird display. Generates the 8-bit column pattern fed into the `right` input of the rightmost column register. Emits empty columns and pipe columns on the same tick cadence as the shift stages. Each pipe gets a pseudo-random 3-row gap. Freezes on `lossDetect`, exactly like the shift stages, so the whole field stalls together.

---
 rtl/flappy_pkg.sv | 34 +++
 rtl/pipe_lfsr.sv | 38 +++
 rtl/pipe_spawner.sv | 134 +++++++++++++
 tb/tb_pipe_spawner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants, types and helpers for the Flappy Bird 8x8 display.
//   ROWS         : display height, one bit per row in a column word
//   TICK_W       : width of the column-shift tick counters
//   DEFAULT_SEED : reset value of the pipe-gap LFSR
//   spawn_state_t: pipe spawner phase (empty spacing vs. pipe body)
package flappy_pkg;

    localparam int unsigned     ROWS         = 8;
    localparam int unsigned     TICK_W       = 12;
    localparam logic [ROWS-1:0] DEFAULT_SEED = 8'hA5;

    typedef enum logic {
        SPACE,
        PIPE
    } spawn_state_t;

    // Fold a raw 3-bit value into a gap start row so the gap stays inside rows 0..7.
    function automatic logic [2:0] fold_gap(input logic [2:0] v, input int unsigned gap_h);
        int unsigned vi;
        vi = 32'(v);
        if (vi > (8 - gap_h)) begin
            return 3'(vi - (9 - gap_h));
        end
        return v;
    endfunction

    // Column pattern: all rows lit except gap_h rows starting at row g.
    function automatic logic [ROWS-1:0] gap_pattern(input logic [2:0] g, input int unsigned gap_h);
        logic [31:0] mask;
        mask = ((32'd1 << gap_h) - 32'd1) << g;
        return ROWS'(~mask);
    endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only when step_en is high.
//   clock, reset : system clock, synchronous active-high reset (loads SEED)
//   step_en      : advance one step on this edge
//   lfsr_q       : current register value
//   lfsr_next_c  : combinational post-step value, usable in the same edge as the step
module pipe_lfsr
    import flappy_pkg::*;
#(
    parameter logic [ROWS-1:0] SEED = DEFAULT_SEED
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            step_en,
    output logic [ROWS-1:0] lfsr_q,
    output logic [ROWS-1:0] lfsr_next_c
);

    logic [ROWS-1:0] lfsr_d;

    // Next value and hold/step selection.
    always_comb begin
        lfsr_next_c = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        lfsr_d      = lfsr_q;
        if (step_en) begin
            lfsr_d = lfsr_next_c;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/pipe_spawner.sv
// Source end of the pipe-column shift chain: emits SPACE empty columns followed by
// PIPE_W pipe columns (each pipe with a pseudo-random GAP_H-row gap), one column per
// TICK_PERIOD cycles. lossDetect freezes everything so the field stalls together.
//   clock, reset : system clock, synchronous active-high reset
//   lossDetect   : game-over hold; restarts the tick counter and blocks updates
//   column_out   : next column word for the shift chain (bit i = row i, 1 = pipe)
//   tick         : one-cycle pulse in the first cycle a new column_out is visible
//   pipe_start   : one-cycle pulse, with tick, on the first column of each pipe
module pipe_spawner #(
    parameter int unsigned                 TICK_PERIOD = 2560,
    parameter int unsigned                 GAP_H       = 3,
    parameter int unsigned                 PIPE_W      = 1,
    parameter int unsigned                 SPACE       = 3,
    parameter logic [flappy_pkg::ROWS-1:0] SEED        = flappy_pkg::DEFAULT_SEED
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        lossDetect,
    output logic [flappy_pkg::ROWS-1:0] column_out,
    output logic                        tick,
    output logic                        pipe_start
);

    localparam int unsigned ROWS    = flappy_pkg::ROWS;
    localparam int unsigned TICK_W  = flappy_pkg::TICK_W;
    localparam int unsigned CNT_MAX = (PIPE_W > SPACE) ? PIPE_W : SPACE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_PERIOD - 1);
    localparam logic [CNT_W-1:0]  SPACE_LAST = CNT_W'(SPACE - 1);
    localparam logic [CNT_W-1:0]  PIPE_LAST  = CNT_W'(PIPE_W - 1);

    flappy_pkg::spawn_state_t state_q, state_d;
    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
    logic [2:0]        gap_lo_q, gap_lo_d;
    logic [ROWS-1:0]   column_q, column_d;
    logic              tick_q, tick_d;
    logic              pipe_start_q, pipe_start_d;
    logic              lfsr_step_c;
    logic [ROWS-1:0]   lfsr_q;
    logic [ROWS-1:0]   lfsr_next_c;

    // Gap source; steps once per pipe so the gap row is stable across a multi-column pipe.
    pipe_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clock       (clock),
        .reset       (reset),
        .step_en     (lfsr_step_c),
        .lfsr_q      (lfsr_q),
        .lfsr_next_c (lfsr_next_c)
    );

    // Tick counter and spawner FSM next-state; lossDetect outranks the terminal count.
    always_comb begin
        cnt_d        = cnt_q + TICK_W'(1);
        state_d      = state_q;
        col_cnt_d    = col_cnt_q;
        gap_lo_d     = gap_lo_q;
        column_d     = column_q;
        tick_d       = 1'b0;
        pipe_start_d = 1'b0;
        lfsr_step_c  = 1'b0;

        if (lossDetect) begin
            cnt_d = '0;
        end else if (cnt_q == TICK_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            unique case (state_q)
                flappy_pkg::SPACE: begin
                    column_d = '0;
                    if (col_cnt_q == SPACE_LAST) begin
                        col_cnt_d = '0;
                        state_d   = flappy_pkg::PIPE;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
                flappy_pkg::PIPE: begin
                    if (col_cnt_q == '0) begin
                        // New pipe: the gap uses the post-step LFSR value of this same edge.
                        lfsr_step_c  = 1'b1;
                        gap_lo_d     = flappy_pkg::fold_gap(lfsr_next_c[2:0], GAP_H);
                        column_d     = flappy_pkg::gap_pattern(gap_lo_d, GAP_H);
                        pipe_start_d = 1'b1;
                    end else begin
                        column_d = flappy_pkg::gap_pattern(gap_lo_q, GAP_H);
                    end
                    if (col_cnt_q == PIPE_LAST) begin
                        col_cnt_d = '0;
                        state_d   = flappy_pkg::SPACE;
                    end else begin
                        col_cnt_d = col_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = flappy_pkg::SPACE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= flappy_pkg::SPACE;
            cnt_q        <= '0;
            col_cnt_q    <= '0;
            gap_lo_q     <= '0;
            column_q     <= '0;
            tick_q       <= 1'b0;
            pipe_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            col_cnt_q    <= col_cnt_d;
            gap_lo_q     <= gap_lo_d;
            column_q     <= column_d;
            tick_q       <= tick_d;
            pipe_start_q <= pipe_start_d;
        end
    end

    // A nonzero seed can never reach the all-zero lock-up state.
    lfsr_nonzero_a: assert property (@(posedge clock) disable iff (reset)
        (lfsr_q != '0) && (lfsr_next_c != '0));

    assign column_out = column_q;
    assign tick       = tick_q;
    assign pipe_start = pipe_start_q;

endmodule

// File: tb/tb_pipe_spawner.sv
module tb_pipe_spawner;

    logic       clk = 1'b0;
    logic       reset_a, rst_b, rst_c;
    logic       loss_a;
    logic       loss_bc;
    logic [7:0] col_a, col_b, col_c;
    logic       tick_a, tick_b, tick_c;
    logic       ps_a, ps_b, ps_c;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] col;
        logic       ps;
    } vec_t;

    typedef struct {
        logic [7:0] col_b;
        logic       ps_b;
        logic [7:0] col_c;
        logic       ps_c;
    } vec_bc_t;

    always #5 clk = ~clk;

    pipe_spawner #(.TICK_PERIOD(4)) dut_a (
        .clock(clk), .reset(reset_a), .lossDetect(loss_a),
        .column_out(col_a), .tick(tick_a), .pipe_start(ps_a)
    );

    pipe_spawner #(.TICK_PERIOD(4), .PIPE_W(2), .SPACE(1)) dut_b (
        .clock(clk), .reset(rst_b), .lossDetect(loss_bc),
        .column_out(col_b), .tick(tick_b), .pipe_start(ps_b)
    );

    pipe_spawner #(.TICK_PERIOD(4), .PIPE_W(2), .SPACE(3)) dut_c (
        .clock(clk), .reset(rst_c), .lossDetect(loss_bc),
        .column_out(col_c), .tick(tick_c), .pipe_start(ps_c)
    );

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    // Compare one DUT's outputs at the current sample point.
    task automatic chk_dut(input int which, input string nm, input logic tk,
                           input logic ps, input logic chk_col, input logic [7:0] col);
        logic [7:0] c;
        logic       t, p;
        case (which)
            0:       begin c = col_a; t = tick_a; p = ps_a; end
            1:       begin c = col_b; t = tick_b; p = ps_b; end
            default: begin c = col_c; t = tick_c; p = ps_c; end
        endcase
        chk({nm, ".tick"}, 8'(t), 8'(tk));
        chk({nm, ".pipe_start"}, 8'(p), 8'(ps));
        if (chk_col) chk({nm, ".column"}, c, col);
    endtask

    // Four edges: no tick on the first three, the update on the fourth.
    task automatic upd(input int which, input string nm, input logic [7:0] col, input logic ps);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 3) chk_dut(which, nm, 1'b0, 1'b0, 1'b0, 8'h00);
            else       chk_dut(which, nm, 1'b1, ps, 1'b1, col);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tab_a [31];
        vec_bc_t    tab_bc [6];
        logic [7:0] pipes [7];

        pipes = '{8'hE3, 8'h1F, 8'hE3, 8'h8F, 8'hF1, 8'hC7, 8'hF1};
        for (int i = 0; i < 31; i++) begin
            if ((i % 4) == 3) tab_a[i] = '{col: pipes[i / 4], ps: 1'b1};
            else              tab_a[i] = '{col: 8'h00, ps: 1'b0};
        end
        tab_bc = '{
            '{col_b: 8'h00, ps_b: 1'b0, col_c: 8'h00, ps_c: 1'b0},
            '{col_b: 8'hE3, ps_b: 1'b1, col_c: 8'h00, ps_c: 1'b0},
            '{col_b: 8'hE3, ps_b: 1'b0, col_c: 8'h00, ps_c: 1'b0},
            '{col_b: 8'h00, ps_b: 1'b0, col_c: 8'hE3, ps_c: 1'b1},
            '{col_b: 8'h1F, ps_b: 1'b1, col_c: 8'hE3, ps_c: 1'b0},
            '{col_b: 8'h1F, ps_b: 1'b0, col_c: 8'h00, ps_c: 1'b0}
        };

        reset_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        loss_a  = 1'b0; loss_bc = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk_dut(0, "reset_a", 1'b0, 1'b0, 1'b1, 8'h00);
        reset_a = 1'b0;

        // Free-run: three spaces then a pipe, gap sequence from the seed.
        for (int i = 0; i < 31; i++) begin
            upd(0, $sformatf("freerun[%0d]", i + 1), tab_a[i].col, tab_a[i].ps);
        end

        // Hold for 6 cycles mid-period.
        @(negedge clk);
        chk_dut(0, "prehold", 1'b0, 1'b0, 1'b1, 8'h00);
        loss_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_dut(0, $sformatf("hold[%0d]", i), 1'b0, 1'b0, 1'b1, 8'h00);
        end
        loss_a = 1'b0;
        upd(0, "after_hold", 8'hF8, 1'b1);

        // Hold exactly on the terminal-count edge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_dut(0, $sformatf("pre_tc[%0d]", i), 1'b0, 1'b0, 1'b1, 8'hF8);
        end
        loss_a = 1'b1;
        @(negedge clk);
        chk_dut(0, "hold_on_tc", 1'b0, 1'b0, 1'b1, 8'hF8);
        loss_a = 1'b0;
        upd(0, "after_tc_hold", 8'h00, 1'b0);

        // Wider pipes, run b and c side by side.
        rst_b = 1'b0; rst_c = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (c < 3) begin
                    chk_dut(1, $sformatf("b[%0d]", i + 1), 1'b0, 1'b0, 1'b0, 8'h00);
                    chk_dut(2, $sformatf("c[%0d]", i + 1), 1'b0, 1'b0, 1'b0, 8'h00);
                end else begin
                    chk_dut(1, $sformatf("b[%0d]", i + 1), 1'b1, tab_bc[i].ps_b, 1'b1, tab_bc[i].col_b);
                    chk_dut(2, $sformatf("c[%0d]", i + 1), 1'b1, tab_bc[i].ps_c, 1'b1, tab_bc[i].col_c);
                end
            end
        end

        // Reset mid-pipe: restart from the seed.
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        for (int i = 0; i < 3; i++) upd(2, $sformatf("c_run[%0d]", i + 1), 8'h00, 1'b0);
        upd(2, "c_run[4]", 8'hE3, 1'b1);
        @(negedge clk);
        chk_dut(2, "c_pipe_showing", 1'b0, 1'b0, 1'b1, 8'hE3);
        rst_c = 1'b1;
        @(negedge clk);
        chk_dut(2, "c_midreset", 1'b0, 1'b0, 1'b1, 8'h00);
        rst_c = 1'b0;
        for (int i = 0; i < 3; i++) upd(2, $sformatf("c_rerun[%0d]", i + 1), 8'h00, 1'b0);
        upd(2, "c_rerun[4]", 8'hE3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
